// File: rtl/lcd_text_seq.sv
// lcd_text_seq: replays a 32-character screen buffer to the LCD core as a handshaked command stream
module lcd_text_seq #(
    parameter logic [15:0] core_addr = 16'h17,
    parameter logic [15:0] lcd_addr  = 16'h16,
    parameter int          LINE_LEN  = 16
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        en,
    input  logic [15:0] addr,
    input  logic [15:0] data_i,
    output logic        busy,
    output logic        done,
    output logic        lcd_en,
    output logic [15:0] lcd_addr_o,
    output logic [15:0] lcd_data,
    output logic [2:0]  lcd_cmd,
    input  logic        lcd_done
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, FIN} state_t;
    typedef enum logic [2:0] {OP_INIT, OP_CLEAR, OP_HOME, OP_TEXT1, OP_LINE2, OP_TEXT2} op_t;

    localparam logic [4:0] LAST1 = 5'(LINE_LEN - 1);
    localparam logic [4:0] LAST2 = 5'(2 * LINE_LEN - 1);

    state_t      state;
    op_t         op;
    op_t         nxt_op;
    op_t         first_op;
    logic [4:0]  idx;
    logic [4:0]  nxt_idx;
    logic [15:0] nxt_data;
    logic        init_done;
    logic        last_op;
    logic        wr_hit;
    logic        start;
    logic        wr_char;
    logic        unused_bits;
    logic [7:0]  char_buf [0:2*LINE_LEN-1];

    function automatic logic [2:0] cmd_of(input op_t o);
        return o == OP_INIT  ? 3'd1 :
               o == OP_CLEAR ? 3'd6 :
               o == OP_HOME  ? 3'd4 :
               o == OP_LINE2 ? 3'd3 : 3'd2;
    endfunction

    function automatic logic is_text(input op_t o);
        return o == OP_TEXT1 || o == OP_TEXT2;
    endfunction

    assign wr_hit      = en && addr == core_addr;
    assign start       = wr_hit && data_i[15];
    assign wr_char     = wr_hit && !data_i[15] && !busy;
    assign unused_bits = ^data_i[14:13];
    assign first_op    = init_done ? OP_CLEAR : OP_INIT;

    // Successor of the current operation in the refresh list
    always_comb begin
        last_op  = op == OP_TEXT2 && idx == LAST2;
        nxt_op   = op == OP_INIT  ? OP_CLEAR :
                   op == OP_CLEAR ? OP_HOME  :
                   op == OP_HOME  ? OP_TEXT1 :
                   (op == OP_TEXT1 && idx == LAST1) ? OP_LINE2 :
                   op == OP_LINE2 ? OP_TEXT2 : op;
        nxt_idx  = is_text(op) ? idx + 5'd1 : idx;
        nxt_data = is_text(nxt_op) ? {8'h00, char_buf[nxt_idx]} : 16'h0000;
    end

    // Screen buffer: host character writes, frozen while a refresh runs
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 2 * LINE_LEN; i++) char_buf[i] <= 8'h20;
        end else if (wr_char) begin
            char_buf[data_i[12:8]] <= data_i[7:0];
        end
    end

    // Refresh sequencer with registered LCD-side and host-side outputs
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            op         <= OP_INIT;
            idx        <= 5'd0;
            init_done  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            lcd_en     <= 1'b0;
            lcd_addr_o <= 16'h0000;
            lcd_cmd    <= 3'd0;
            lcd_data   <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    state      <= ISSUE;
                    busy       <= 1'b1;
                    op         <= first_op;
                    idx        <= 5'd0;
                    lcd_en     <= 1'b1;
                    lcd_addr_o <= lcd_addr;
                    lcd_cmd    <= cmd_of(first_op);
                    lcd_data   <= 16'h0000;
                end
                ISSUE: state <= WAIT;
                WAIT: if (lcd_done) begin
                    state      <= GAP;
                    lcd_en     <= 1'b0;
                    lcd_addr_o <= 16'h0000;
                    if (op == OP_INIT) init_done <= 1'b1;
                end
                GAP: if (last_op) begin
                    state    <= FIN;
                    done     <= 1'b1;
                    lcd_cmd  <= 3'd0;
                    lcd_data <= 16'h0000;
                end else begin
                    state      <= ISSUE;
                    op         <= nxt_op;
                    idx        <= nxt_idx;
                    lcd_en     <= 1'b1;
                    lcd_addr_o <= lcd_addr;
                    lcd_cmd    <= cmd_of(nxt_op);
                    lcd_data   <= nxt_data;
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_text_seq.sv
// tb_lcd_text_seq: randomized scoreboard bench for the LCD text sequencer
module tb_lcd_text_seq;
    localparam logic [15:0] CORE = 16'h17;
    localparam logic [15:0] LCD  = 16'h16;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        en = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_i = 16'h0000;
    logic        busy, done, lcd_en, lcd_done;
    logic [15:0] lcd_addr_o, lcd_data;
    logic [2:0]  lcd_cmd;

    int checks = 0;
    int failures = 0;

    logic [18:0] exp_q[$];
    int          exp_done = 0;
    logic [7:0]  m_buf [32];
    bit          m_init = 1'b0;
    bit          m_busy = 1'b0;

    int  dly = 3;
    bit  hold_mode = 1'b0;
    int  cnt = 0;

    int          done_cnt = 0;
    int          sends_in_ref = 0;
    int          ops_in_ref = 0;
    int          low_cnt = 0;
    bit          prev_en = 1'b0;
    bit          prev_done = 1'b0;
    logic [18:0] cur = '0;

    lcd_text_seq dut (
        .clk(clk), .Reset(Reset), .en(en), .addr(addr), .data_i(data_i),
        .busy(busy), .done(done), .lcd_en(lcd_en), .lcd_addr_o(lcd_addr_o),
        .lcd_data(lcd_data), .lcd_cmd(lcd_cmd), .lcd_done(lcd_done)
    );

    always #5 clk = ~clk;

    // LCD core model: registered done flag after dly enabled cycles, or held high
    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            lcd_done <= 1'b0;
            cnt      <= 0;
        end else if (hold_mode) begin
            lcd_done <= 1'b1;
        end else if (!lcd_en) begin
            lcd_done <= 1'b0;
            cnt      <= 0;
        end else begin
            cnt <= cnt + 1;
            if (cnt + 1 >= dly) lcd_done <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        m_init = 1'b0;
        m_busy = 1'b0;
        exp_q.delete();
        exp_done = 0;
    endtask

    // Expected command stream of one refresh, straight from the operation list
    task automatic push_ref();
        if (!m_init) exp_q.push_back({3'd1, 16'h0000});
        m_init = 1'b1;
        exp_q.push_back({3'd6, 16'h0000});
        exp_q.push_back({3'd4, 16'h0000});
        for (int i = 0; i < 16; i++) exp_q.push_back({3'd2, 8'h00, m_buf[i]});
        exp_q.push_back({3'd3, 16'h0000});
        for (int i = 16; i < 32; i++) exp_q.push_back({3'd2, 8'h00, m_buf[i]});
        exp_done++;
        m_busy = 1'b1;
    endtask

    task automatic bus(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        en = 1'b1;
        addr = a;
        data_i = d;
        @(negedge clk);
        en = 1'b0;
        addr = 16'h0000;
        data_i = 16'h0000;
    endtask

    task automatic write_char(input int i, input logic [7:0] c);
        bus(CORE, {3'b000, 5'(i), c});
        if (!m_busy) m_buf[i] = c;
    endtask

    task automatic start_refresh();
        bit acc;
        acc = !m_busy;
        if (acc) push_ref();
        bus(CORE, {1'b1, 15'($urandom)});
        if (acc) chk("start_busy_en", {30'd0, busy, lcd_en}, 32'd3);
    endtask

    task automatic wait_done();
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == base) begin
            failures++;
            $display("FAIL done_timeout actual=none required=done pulse");
        end
        m_busy = 1'b0;
    endtask

    task automatic wait_sends(input int k);
        int n;
        n = 0;
        while (sends_in_ref < k && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sends_in_ref < k) begin
            failures++;
            $display("FAIL send_timeout actual=%0d required=%0d", sends_in_ref, k);
        end
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #3 Reset = 1'b1;
        #1;
        chk({tag, "_outs"}, {busy, done, lcd_en, lcd_cmd, lcd_data, lcd_addr_o}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;
    endtask

    // Monitor: pops expected operations when the DUT presents them and checks handshake spacing
    initial begin
        forever begin
            @(negedge clk);
            if (Reset) begin
                prev_en = 1'b0;
                prev_done = 1'b0;
                low_cnt = 0;
                ops_in_ref = 0;
                sends_in_ref = 0;
            end else begin
                chk("lcd_addr_o", {16'd0, lcd_addr_o}, lcd_en ? {16'd0, LCD} : 32'd0);
                if (lcd_en && !prev_en) begin
                    if (ops_in_ref > 0) chk("gap_len", low_cnt, 1);
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL op_unexpected actual=%h required=none", {lcd_cmd, lcd_data});
                    end else begin
                        cur = exp_q.pop_front();
                        if ({lcd_cmd, lcd_data} !== cur) begin
                            failures++;
                            $display("FAIL op actual=%h required=%h", {lcd_cmd, lcd_data}, cur);
                        end
                    end
                    cur = {lcd_cmd, lcd_data};
                    ops_in_ref++;
                    if (lcd_cmd == 3'd2) sends_in_ref++;
                end else if (lcd_en) begin
                    chk("op_hold", {13'd0, lcd_cmd, lcd_data}, {13'd0, cur});
                end
                if (done) begin
                    chk("done_gap", low_cnt, 1);
                    chk("done_ops_left", exp_q.size(), 0);
                    checks++;
                    if (exp_done == 0) begin
                        failures++;
                        $display("FAIL done_unexpected actual=1 required=0");
                    end else begin
                        exp_done--;
                    end
                    done_cnt++;
                    ops_in_ref = 0;
                    sends_in_ref = 0;
                end
                if (prev_done) chk("after_done", {30'd0, done, busy}, 32'd0);
                low_cnt = lcd_en ? 0 : low_cnt + 1;
                prev_en = lcd_en;
                prev_done = done;
            end
        end
    end

    // Stimulus
    initial begin
        model_reset();
        #1 Reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;

        // reset values, then an all-space first refresh
        async_reset("t1_reset");
        start_refresh();
        wait_done();

        // first refresh after reset with HELLO / WORLD
        async_reset("t2_reset");
        write_char(0, "H"); write_char(1, "E"); write_char(2, "L"); write_char(3, "L"); write_char(4, "O");
        write_char(16, "W"); write_char(17, "O"); write_char(18, "R"); write_char(19, "L"); write_char(20, "D");
        dly = 3;
        start_refresh();
        wait_done();

        // second refresh: no INIT
        start_refresh();
        wait_done();

        // bus activity while busy is dropped; stray addresses are ignored
        for (int i = 0; i < 32; i++) write_char(i, (i == 5) ? 8'h20 : 8'($urandom_range(33, 126)));
        bus(16'h0016, {3'b000, 5'd7, 8'h41});
        dly = int'($urandom_range(1, 4));
        start_refresh();
        wait_sends(3);
        write_char(5, "X");
        start_refresh();
        wait_done();
        repeat (10) @(negedge clk);
        chk("no_extra_done", exp_done, 0);
        start_refresh();
        wait_done();

        // done held high continuously
        hold_mode = 1'b1;
        start_refresh();
        wait_done();
        hold_mode = 1'b0;
        repeat (3) @(negedge clk);

        // randomized rounds
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 6; k++) write_char(int'($urandom_range(0, 31)), 8'($urandom));
            dly = int'($urandom_range(1, 5));
            start_refresh();
            wait_done();
        end

        // reset during the 10th SEND_BYTE, then INIT and spaces again
        dly = 3;
        start_refresh();
        wait_sends(10);
        async_reset("t6_reset");
        start_refresh();
        wait_done();

        repeat (20) @(negedge clk);
        chk("final_queue", exp_q.size(), 0);
        chk("final_done", exp_done, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_text_seq.md
# lcd_text_seq

Two-line text sequencer that sits directly upstream of the character-LCD core on the 16-bit peripheral bus. The host writes up to 32 characters into an internal screen buffer and then issues a refresh. The block replays that buffer to the LCD core as a command stream (INIT once, CLEAR, HOME, 16×SEND_BYTE, LINE_2, 16×SEND_BYTE), handshaking on the core's done flag. The host therefore issues one write instead of 35 to 36 individually polled LCD commands.

## Interface
Parameters:
- `core_addr`, default 'h17: bus address decoded by this block.
- `lcd_addr`, default 'h16: bus address of the downstream LCD core.
- `LINE_LEN`, default 16: characters per line. The buffer holds 2×LINE_LEN characters. Only 16 is supported.

Ports:
- `clk`, in, 1: the single clock.
- `Reset`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: host bus strobe.
- `addr`, in, 16: host bus address.
- `data_i`, in, 16: host write data. If bit15=1, start a refresh and ignore all other bits. If bit15=0, write a character: bits[12:8] are the index (0–15 line 1, 16–31 line 2) and bits[7:0] are the character.
- `busy`, out, 1: high while a refresh is in progress.
- `done`, out, 1: one-cycle pulse when a refresh completes.
- `lcd_en`, out, 1: enable to the LCD core.
- `lcd_addr_o`, out, 16: equals `lcd_addr` while `lcd_en`=1, otherwise 0.
- `lcd_data`, out, 16: {8'h00, char}. Value is 0 for non-SEND_BYTE operations.
- `lcd_cmd`, out, 3: LCD command code. INIT=1, SEND_BYTE=2, LINE_2=3, HOME=4, CLEAR=6.
- `lcd_done`, in, 1: done flag from the LCD core. It is registered there and drops after `lcd_en` falls.

## Operation
Host access:
- A bus write is accepted on a rising edge when `en`=1 and `addr`==`core_addr`.
- Character writes update `buf[idx]` only when `busy`=0. While `busy`=1 they are dropped.
- A start while `busy`=0 begins a refresh. A start while `busy`=1 is ignored. Starts are not queued.

Initialisation tracking:
- `init_done` is cleared by reset.
- It is set when the INIT operation completes.
- INIT is issued only on the first refresh after reset.

FSM states: IDLE, ISSUE, WAIT, GAP, FIN.
- Operation list, in order:
  1. INIT, only if `init_done`=0.
  2. CLEAR.
  3. HOME.
  4. SEND_BYTE for `buf[0..15]`.
  5. LINE_2.
  6. SEND_BYTE for `buf[16..31]`.
- An operation pointer and a 5-bit character index track progress through the list.
- Transitions:
  - IDLE → ISSUE on an accepted start.
  - ISSUE: drive `lcd_en`=1 with `lcd_cmd`, `lcd_addr_o` and `lcd_data` for the current operation, then go to WAIT.
  - WAIT: hold all LCD outputs stable until `lcd_done`=1 is sampled, then go to GAP.
  - GAP: `lcd_en`=0 for exactly one cycle. This lets the core clear its counter and `isDone`. Then go to ISSUE if operations remain, otherwise FIN.
  - FIN: pulse `done`=1 and return to IDLE. `busy` falls at the same edge.
- The buffer is read live. Because writes are blocked while busy, the buffer content is frozen for the whole refresh.

Reset:
- Applies immediately, including mid-operation.
- All outputs go to 0.
- State goes to IDLE and `init_done` is cleared.
- Every buffer byte is set to 8'h20 (space).
- Any operation in flight is abandoned, not completed.

## Timing
- All outputs are registered and change only on rising `clk` edges, apart from the asynchronous reset.
- An accepted start at edge T gives `busy`=1 and `lcd_en`=1 (first operation) from T+1.
- If `lcd_done` is sampled high at edge D, then `lcd_en`=0 during D+1 to D+2, and the next operation's `lcd_en`=1 from D+2.
- `lcd_cmd` and `lcd_data` for the next operation may change at the GAP edge or the ISSUE edge. They must be valid whenever `lcd_en`=1.
- After the last operation's `lcd_done` at edge D: GAP occupies D+1, and `done`=1 for the single cycle starting D+2, with `busy`=0 from D+3.
- `lcd_done` asserted while in IDLE or GAP is ignored.
- There is no timeout. If `lcd_done` never rises, `busy` stays high until reset.
- A character write at edge T is visible to a refresh started at T+1 or later.
- Operations per refresh: 36 (first refresh after reset) or 35 (subsequent refreshes).

## Test plan
Test 1: reset values.
- Stimulus: assert `Reset` mid-cycle.
- Required response: `busy`, `done`, `lcd_en`, `lcd_cmd`, `lcd_data` and `lcd_addr_o` are all 0 immediately.
- Then start a refresh with no character writes: 32 SEND_BYTE operations with `lcd_data`=16'h0020.

Test 2: first refresh.
- Stimulus: write "HELLO" at indices 0–4 and "WORLD" at 16–20, then start. The LCD model returns `lcd_done` 3 cycles after `lcd_en`.
- Required response: exactly 36 operations in the order 1, 6, 4, 2×16, 3, 2×16, with the characters in index order and `done` pulsing once.

Test 3: second refresh.
- Stimulus: start again after the first refresh completes.
- Required response: 35 operations beginning with CLEAR (6), with no INIT.

Test 4: bus activity while busy.
- Stimulus: during a refresh, write index 5 = 'X' and issue a start.
- Required response: both writes are ignored. A later refresh shows a space at index 5, and exactly one `done` pulse follows the original start.

Test 5: handshake spacing.
- Stimulus: the model holds `lcd_done` high continuously.
- Required response: every operation still shows exactly one `lcd_en`=0 gap cycle, and `lcd_en` is never high for two different commands without a gap.

Test 6: reset mid-operation.
- Stimulus: assert `Reset` during the 10th SEND_BYTE.
- Required response: outputs go to 0 at once, and the next refresh reissues INIT and sends all spaces.
